// File: rtl/am_envelope_decim.sv
// ============================================================================
// Module   : am_envelope_decim
// Brief    : AM envelope detector - rectify, boxcar-decimate, remove carrier DC.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module am_envelope_decim #(
    parameter int DECIM_LOG2 = 6,
    parameter int DC_SHIFT   = 4
) (
    input  logic               clk,
    input  logic               RSTb,
    input  logic signed [7:0]  if_in,
    input  logic               in_valid,
    output logic signed [9:0]  audio_out,
    output logic               audio_valid,
    output logic        [9:0]  dc_level,
    output logic               clip_out
);

    localparam int c_ACC_W = DECIM_LOG2 + 8;
    localparam int c_DC_W  = 10 + DC_SHIFT;

    logic [7:0]              w_raw;
    logic [7:0]              w_abs;
    logic                    w_clip;
    logic                    w_last;
    logic [c_ACC_W-1:0]      w_sum;
    logic signed [10:0]      w_diff;
    logic [9:0]              w_sat;
    logic [c_DC_W-1:0]       w_dc_next;

    logic [DECIM_LOG2-1:0]   r_cnt;
    logic [c_ACC_W-1:0]      r_acc;
    logic                    r_clip;
    logic [9:0]              r_env;
    logic                    r_env_v;
    logic                    r_blk_clip;
    logic [c_DC_W-1:0]       r_dc_acc;

    // Two's-complement negate of 0x80 yields 0x80, which read unsigned is 128.
    assign w_raw  = if_in;
    assign w_abs  = w_raw[7] ? (~w_raw + 8'd1) : w_raw;
    assign w_clip = (w_raw == 8'h7F) || (w_raw == 8'h80);
    assign w_last = &r_cnt;
    assign w_sum  = r_acc + c_ACC_W'(w_abs);

    always_ff @(posedge clk) begin
        if (!RSTb) begin
            r_cnt      <= '0;
            r_acc      <= '0;
            r_clip     <= 1'b0;
            r_env      <= '0;
            r_env_v    <= 1'b0;
            r_blk_clip <= 1'b0;
        end else begin
            r_env_v <= 1'b0;
            if (in_valid) begin
                if (w_last) begin
                    // Top 10 bits of the block sum: average scaled by 4.
                    r_env      <= w_sum[c_ACC_W-1 -: 10];
                    r_env_v    <= 1'b1;
                    r_blk_clip <= r_clip | w_clip;
                    r_acc      <= '0;
                    r_cnt      <= '0;
                    r_clip     <= 1'b0;
                end else begin
                    r_acc  <= w_sum;
                    r_cnt  <= r_cnt + DECIM_LOG2'(1);
                    r_clip <= r_clip | w_clip;
                end
            end
        end
    end

    assign dc_level  = r_dc_acc[c_DC_W-1 -: 10];
    assign w_diff    = $signed({1'b0, r_env}) - $signed({1'b0, dc_level});
    assign w_dc_next = r_dc_acc + c_DC_W'(r_env) - c_DC_W'(dc_level);

    always_comb begin
        w_sat = w_diff[9:0];
        if (!w_diff[10] && w_diff[9]) begin
            w_sat = 10'h1FF;
        end else if (w_diff[10] && !w_diff[9]) begin
            w_sat = 10'h200;
        end
    end

    always_ff @(posedge clk) begin
        if (!RSTb) begin
            audio_out   <= '0;
            audio_valid <= 1'b0;
            clip_out    <= 1'b0;
            r_dc_acc    <= '0;
        end else begin
            audio_valid <= r_env_v;
            if (r_env_v) begin
                audio_out <= $signed(w_sat);
                clip_out  <= r_blk_clip;
                r_dc_acc  <= w_dc_next;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_am_envelope_decim.sv
// ============================================================================
// Module   : tb_am_envelope_decim
// Brief    : Scoreboard bench for am_envelope_decim (DECIM_LOG2=6 and =2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_am_envelope_decim;

    logic              clk = 1'b0;
    logic              RSTb;
    logic signed [7:0] if_in;
    logic              in_valid;
    logic signed [9:0] audio_out;
    logic              audio_valid;
    logic        [9:0] dc_level;
    logic              clip_out;

    logic              RSTb2;
    logic signed [7:0] if_in2;
    logic              in_valid2;
    logic signed [9:0] audio_out2;
    logic              audio_valid2;
    logic        [9:0] dc_level2;
    logic              clip_out2;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int rel    = 0;

    int exp_audio_q[$];
    bit exp_clip_q[$];
    int log_audio[$];
    int log_cyc[$];
    int log_dc[$];
    bit log_clip[$];

    int m_acc, m_cnt, m_dc;
    bit m_clip;

    am_envelope_decim #(.DECIM_LOG2(6), .DC_SHIFT(4)) dut (
        .clk(clk), .RSTb(RSTb), .if_in(if_in), .in_valid(in_valid),
        .audio_out(audio_out), .audio_valid(audio_valid),
        .dc_level(dc_level), .clip_out(clip_out)
    );

    am_envelope_decim #(.DECIM_LOG2(2), .DC_SHIFT(4)) dut2 (
        .clk(clk), .RSTb(RSTb2), .if_in(if_in2), .in_valid(in_valid2),
        .audio_out(audio_out2), .audio_valid(audio_valid2),
        .dc_level(dc_level2), .clip_out(clip_out2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every strobe pops one expected block result.
    always @(negedge clk) begin
        if (audio_valid) begin
            checks++;
            if (exp_audio_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: got audio=%0d, required no strobe", audio_out);
            end else begin
                int ea;
                bit ec;
                ea = exp_audio_q.pop_front();
                ec = exp_clip_q.pop_front();
                if (int'(audio_out) !== ea || clip_out !== ec) begin
                    errors++;
                    $display("FAIL scoreboard: got audio=%0d clip=%0b, required audio=%0d clip=%0b",
                             audio_out, clip_out, ea, ec);
                end
            end
            log_audio.push_back(int'(audio_out));
            log_clip.push_back(clip_out);
            log_cyc.push_back(cyc);
            log_dc.push_back(int'(dc_level));
        end
    end

    task automatic model_clear();
        m_acc = 0; m_cnt = 0; m_dc = 0; m_clip = 0;
    endtask

    // Inputs are applied just after a falling edge; returns after the next one.
    task automatic drive(input int s, input bit v);
        int a, env, au;
        if_in    = 8'(s);
        in_valid = v;
        if (v) begin
            a = (s < 0) ? -s : s;
            m_acc += a;
            m_clip |= (s == 127 || s == -128);
            m_cnt++;
            if (m_cnt == 64) begin
                env = m_acc / 16;
                au  = env - m_dc / 16;
                if (au > 511)  au = 511;
                if (au < -512) au = -512;
                m_dc += env - m_dc / 16;
                exp_audio_q.push_back(au);
                exp_clip_q.push_back(m_clip);
                m_acc = 0; m_cnt = 0; m_clip = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0);
    endtask

    task automatic do_reset();
        RSTb = 1'b0; in_valid = 1'b0; if_in = '0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_audio_q.size() != 0) begin
            errors++;
            $display("FAIL missing_strobes: got %0d pending, required 0", exp_audio_q.size());
        end
        exp_audio_q.delete();
        exp_clip_q.delete();
        model_clear();
        RSTb = 1'b1;
        rel  = cyc;
    endtask

    task automatic test_reset();
        RSTb = 1'b0; in_valid = 1'b0; if_in = '0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (audio_out !== 10'sd0 || audio_valid !== 1'b0 || dc_level !== 10'd0 || clip_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got audio=%0d valid=%0b dc=%0d clip=%0b, required all 0",
                     audio_out, audio_valid, dc_level, clip_out);
        end
        do_reset();
    endtask

    task automatic test_constant();
        int n0, bad;
        do_reset();
        n0 = log_audio.size();
        repeat (203 * 64) drive(64, 1);
        idle(3);
        checks++;
        if (log_audio.size() - n0 != 203) begin
            errors++;
            $display("FAIL const_count: got %0d strobes, required 203", log_audio.size() - n0);
        end else begin
            checks++;
            if (log_cyc[n0] - rel != 65) begin
                errors++;
                $display("FAIL const_latency: got %0d edges, required 65", log_cyc[n0] - rel);
            end
            checks++;
            if (log_audio[n0] != 256 || log_audio[n0+1] != 240 || log_audio[n0+2] != 225) begin
                errors++;
                $display("FAIL const_first3: got %0d %0d %0d, required 256 240 225",
                         log_audio[n0], log_audio[n0+1], log_audio[n0+2]);
            end
            checks++;
            if (log_dc[n0] != 16) begin
                errors++;
                $display("FAIL const_dc_level: got %0d, required 16", log_dc[n0]);
            end
            bad = 0;
            for (int i = n0 + 1; i < n0 + 203; i++)
                if (log_audio[i] > log_audio[i-1]) bad++;
            checks++;
            if (bad != 0 || log_audio[n0+202] != 0) begin
                errors++;
                $display("FAIL const_decay: got %0d rises, final=%0d, required 0 rises, final=0",
                         bad, log_audio[n0+202]);
            end
        end
    endtask

    task automatic test_clip();
        int n0;
        do_reset();
        n0 = log_audio.size();
        repeat (64) drive(-128, 1);
        idle(3);
        repeat (64) drive(64, 1);
        idle(3);
        checks++;
        if (log_audio.size() - n0 != 2) begin
            errors++;
            $display("FAIL clip_count: got %0d strobes, required 2", log_audio.size() - n0);
        end else begin
            checks++;
            if (log_audio[n0] != 511 || log_clip[n0] !== 1'b1) begin
                errors++;
                $display("FAIL clip_sat: got audio=%0d clip=%0b, required 511 1",
                         log_audio[n0], log_clip[n0]);
            end
            checks++;
            if (log_clip[n0+1] !== 1'b0) begin
                errors++;
                $display("FAIL clip_clear: got clip=%0b, required 0", log_clip[n0+1]);
            end
        end
    endtask

    task automatic test_alternating();
        int n0;
        do_reset();
        n0 = log_audio.size();
        for (int i = 0; i < 64; i++) drive((i % 2 == 0) ? 100 : -100, 1);
        idle(3);
        checks++;
        if (log_audio.size() - n0 != 1 || log_audio[n0] != 400 || log_clip[n0] !== 1'b0) begin
            errors++;
            $display("FAIL alternating: got %0d strobes first=%0d, required 1 strobe audio=400 clip=0",
                     log_audio.size() - n0, (log_audio.size() > n0) ? log_audio[n0] : -9999);
        end
    endtask

    task automatic test_gated_valid();
        int n0;
        do_reset();
        n0 = log_audio.size();
        repeat (3 * 64) begin
            drive(64, 1);
            drive(-77, 0);
        end
        idle(3);
        checks++;
        if (log_audio.size() - n0 != 3) begin
            errors++;
            $display("FAIL gated_count: got %0d strobes, required 3", log_audio.size() - n0);
        end else begin
            checks++;
            if (log_cyc[n0+1] - log_cyc[n0] != 128 || log_cyc[n0+2] - log_cyc[n0+1] != 128) begin
                errors++;
                $display("FAIL gated_spacing: got %0d %0d, required 128 128",
                         log_cyc[n0+1] - log_cyc[n0], log_cyc[n0+2] - log_cyc[n0+1]);
            end
            checks++;
            if (log_audio[n0] != 256 || log_audio[n0+1] != 240 || log_audio[n0+2] != 225) begin
                errors++;
                $display("FAIL gated_values: got %0d %0d %0d, required 256 240 225",
                         log_audio[n0], log_audio[n0+1], log_audio[n0+2]);
            end
        end
    endtask

    task automatic test_mid_block_reset();
        int n0;
        do_reset();
        n0 = log_audio.size();
        repeat (30) drive(64, 1);
        idle(2);
        do_reset();
        checks++;
        if (log_audio.size() != n0) begin
            errors++;
            $display("FAIL partial_block: got %0d strobes, required 0", log_audio.size() - n0);
        end
        repeat (64) drive(64, 1);
        idle(3);
        checks++;
        if (log_audio.size() - n0 != 1 || log_audio[n0] != 256 || log_cyc[n0] - rel != 65) begin
            errors++;
            $display("FAIL resume_block: got %0d strobes audio=%0d edges=%0d, required 1 256 65",
                     log_audio.size() - n0, (log_audio.size() > n0) ? log_audio[n0] : -9999,
                     (log_cyc.size() > n0) ? log_cyc[n0] - rel : -1);
        end
    endtask

    // Short-block instance: env = 4 every 4 valid samples.
    task automatic test_short_block();
        int dc, ea, r2, ev;
        RSTb2 = 1'b1; if_in2 = 8'sd1; in_valid2 = 1'b1;
        r2 = cyc;
        dc = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            ev = (i >= 5 && (i - 5) % 4 == 0) ? 1 : 0;
            checks++;
            if (audio_valid2 !== ev[0]) begin
                errors++;
                $display("FAIL short_strobe: edge %0d got valid=%0b, required %0d", cyc - r2, audio_valid2, ev);
            end
            if (ev == 1) begin
                ea = 4 - dc / 16;
                dc += ea;
                checks++;
                if (int'(audio_out2) !== ea || int'(dc_level2) !== dc / 16 || clip_out2 !== 1'b0) begin
                    errors++;
                    $display("FAIL short_value: got audio=%0d dc=%0d clip=%0b, required %0d %0d 0",
                             audio_out2, dc_level2, clip_out2, ea, dc / 16);
                end
            end
        end
        in_valid2 = 1'b0;
    endtask

    initial begin
        RSTb = 1'b0; if_in = '0; in_valid = 1'b0;
        RSTb2 = 1'b0; if_in2 = '0; in_valid2 = 1'b0;
        model_clear();
        @(negedge clk);
        test_reset();
        test_constant();
        test_clip();
        test_alternating();
        test_gated_valid();
        test_mid_block_reset();
        test_short_block();
        idle(3);
        checks++;
        if (exp_audio_q.size() != 0) begin
            errors++;
            $display("FAIL final_drain: got %0d pending, required 0", exp_audio_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
